// File: rtl/soc_timer.sv
// Memory-mapped SoC timer: prescaled 32-bit up-counter with compare match,
// optional auto-reload and a level interrupt, on a single-cycle core data bus.
module soc_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          PRESC_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  // Bus handshake: req_i is a one-cycle strobe with no ready/stall. A request
  // with sel_o high completes in that cycle: reads return rdata_o combinationally,
  // writes commit on the next rising edge.
  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_PRESC  = 6'h01;
  localparam logic [5:0] OFF_COUNT  = 6'h02;
  localparam logic [5:0] OFF_CMP    = 6'h03;
  localparam logic [5:0] OFF_STATUS = 6'h04;

  logic               en;
  logic               irq_en;
  logic               auto_rl;
  logic               match;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic [31:0]        count;
  logic [31:0]        compare;

  logic [5:0] off;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_presc;
  logic       wr_count;
  logic       wr_cmp;
  logic       wr_status;
  logic       tick;
  logic       hit;
  logic       match_next;
  logic       irq_en_next;
  logic [1:0] unused_addr_bits;

  assign sel_o            = req_i & (addr_i[31:8] == BASE_ADDR[31:8]);
  assign off              = addr_i[7:2];
  assign unused_addr_bits = addr_i[1:0];

  assign wr        = sel_o & we_i;
  assign wr_ctrl   = wr & (off == OFF_CTRL);
  assign wr_presc  = wr & (off == OFF_PRESC);
  assign wr_count  = wr & (off == OFF_COUNT);
  assign wr_cmp    = wr & (off == OFF_CMP);
  assign wr_status = wr & (off == OFF_STATUS);

  assign tick = en & (pcnt == presc);

  // A software COUNT write suppresses both the increment and the match on that edge.
  assign hit         = tick & (count == compare) & ~wr_count;
  assign match_next  = hit | (match & ~(wr_status & wdata_i[0]));
  assign irq_en_next = wr_ctrl ? wdata_i[1] : irq_en;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      auto_rl <= 1'b0;
      presc   <= '0;
      pcnt    <= '0;
      count   <= 32'h0;
      compare <= 32'hFFFF_FFFF;
      match   <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en      <= wdata_i[0];
        irq_en  <= wdata_i[1];
        auto_rl <= wdata_i[2];
      end
      if (wr_presc) presc <= wdata_i[PRESC_W-1:0];
      if (wr_cmp) compare <= wdata_i;

      if (wr_ctrl || wr_presc) pcnt <= '0;
      else if (tick)           pcnt <= '0;
      else if (en)             pcnt <= pcnt + PRESC_W'(1);

      if (wr_count) count <= wdata_i;
      else if (tick) begin
        if ((count == compare) && auto_rl) count <= 32'h0;
        else                               count <= count + 32'd1;
      end

      match <= match_next;
      irq_o <= match_next & irq_en_next;
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    if (sel_o && !we_i) begin
      case (off)
        OFF_CTRL:   rdata_o = {29'h0, auto_rl, irq_en, en};
        OFF_PRESC:  rdata_o = 32'(presc);
        OFF_COUNT:  rdata_o = count;
        OFF_CMP:    rdata_o = compare;
        OFF_STATUS: rdata_o = {31'h0, match};
        default:    rdata_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_timer.sv
// Directed bench for soc_timer: reset values, prescaled counting, auto-reload
// match/interrupt, wrap, simultaneous-event priorities, decode and reset abort.
module tb_soc_timer;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sel;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  soc_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .sel_o  (sel),
    .rdata_o(rdata),
    .irq_o  (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // drivers: writes commit on the posedge after the negedge they are driven on
  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = BASE + {24'h0, off}; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = BASE + {24'h0, off};
    #1;
    d = rdata;
    req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_rst [5];
    exp_rst = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h7;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    rd(8'h0C, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_compare_during: got %h expected %h", v, 32'hFFFF_FFFF); end
    rd(8'h00, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_write_ignored: got %h expected %h", v, 32'h0); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd(8'(i * 4), v);
      checks++; if (v !== exp_rst[i]) begin errors++; $display("FAIL rst_value_off%0h: got %h expected %h", i * 4, v, exp_rst[i]); end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
  endtask

  task automatic test_presc_count();
    logic [31:0] v;
    wr(8'h04, 32'd3);
    wr(8'h00, 32'd1);
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      rd(8'h08, v);
      checks++; if (v !== 32'(k / 4)) begin errors++; $display("FAIL presc_count_k%0d: got %h expected %h", k, v, 32'(k / 4)); end
    end
    wr(8'h00, 32'd0);
  endtask

  task automatic test_auto_reload();
    logic [31:0] v;
    logic [31:0] e;
    wr(8'h00, 32'd0);
    wr(8'h08, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h0C, 32'd5);
    wr(8'h10, 32'd1);
    wr(8'h00, 32'd7);
    exp_q = {};
    for (int i = 0; i <= 5; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'd0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      rd(8'h08, v);
      e = exp_q.pop_front();
      checks++; if (v !== e) begin errors++; $display("FAIL reload_count_k%0d: got %h expected %h", k, v, e); end
      checks++; if (irq !== (k == 6)) begin errors++; $display("FAIL reload_irq_k%0d: got %b expected %b", k, irq, k == 6); end
    end
    rd(8'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL reload_match: got %h expected %h", v, 32'd1); end
    wr(8'h10, 32'd1);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reload_irq_clear: got %b expected 0", irq); end
    rd(8'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reload_match_clear: got %h expected %h", v, 32'd0); end
    wr(8'h00, 32'd0);
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    logic [31:0] e;
    wr(8'h00, 32'd0);
    wr(8'h08, 32'hFFFF_FFFE);
    wr(8'h0C, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h10, 32'd1);
    wr(8'h00, 32'd1);
    exp_q = {32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      rd(8'h08, v);
      e = exp_q.pop_front();
      checks++; if (v !== e) begin errors++; $display("FAIL wrap_count_k%0d: got %h expected %h", k, v, e); end
      rd(8'h10, v);
      checks++; if (v !== 32'(k == 3)) begin errors++; $display("FAIL wrap_match_k%0d: got %h expected %h", k, v, 32'(k == 3)); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wrap_irq_k%0d: got %b expected 0", k, irq); end
    end
    wr(8'h00, 32'd0);
  endtask

  task automatic test_simultaneous();
    logic [31:0] v;
    wr(8'h00, 32'd0);
    wr(8'h10, 32'd1);
    wr(8'h0C, 32'h100);
    wr(8'h08, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h00, 32'd1);
    wr(8'h08, 32'h100);
    @(negedge clk);
    rd(8'h08, v);
    checks++; if (v !== 32'h100) begin errors++; $display("FAIL sim_count_write: got %h expected %h", v, 32'h100); end
    rd(8'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL sim_no_match_on_write: got %h expected %h", v, 32'd0); end
    @(negedge clk);
    rd(8'h08, v);
    checks++; if (v !== 32'h101) begin errors++; $display("FAIL sim_count_after: got %h expected %h", v, 32'h101); end
    rd(8'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL sim_match_after: got %h expected %h", v, 32'd1); end

    wr(8'h00, 32'd0);
    wr(8'h08, 32'h200);
    wr(8'h0C, 32'h200);
    wr(8'h00, 32'd3);
    wr(8'h10, 32'd1);
    @(negedge clk);
    rd(8'h10, v);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL sim_w1c_vs_set: got %h expected %h", v, 32'd1); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sim_irq_set: got %b expected 1", irq); end
    rd(8'h08, v);
    checks++; if (v !== 32'h201) begin errors++; $display("FAIL sim_count_match: got %h expected %h", v, 32'h201); end
    wr(8'h10, 32'd1);
    @(negedge clk);
    rd(8'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL sim_w1c: got %h expected %h", v, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sim_irq_clear: got %b expected 0", irq); end
    wr(8'h00, 32'd0);
  endtask

  task automatic test_decode();
    logic [31:0] v;
    logic [31:0] exp_map [6];
    exp_map = '{32'h0, 32'h0000_FFFF, 32'h1234, 32'hABCD, 32'h0, 32'h0};
    wr(8'h00, 32'hFFFF_FFF8);
    wr(8'h08, 32'h1234);
    wr(8'h0C, 32'hABCD);
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h1C, 32'hFFFF_FFFF);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = BASE + 32'h100; wdata = 32'h7;
    #1;
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL dec_wr_sel: got %b expected 0", sel); end
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = BASE + 32'h100;
    #1;
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL dec_rd_sel: got %b expected 0", sel); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL dec_rd_data: got %h expected %h", rdata, 32'h0); end
    addr = BASE + 32'h0C;
    #1;
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL dec_hit_sel: got %b expected 1", sel); end
    req = 1'b0;
    #1;
    checks++; if (sel !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL dec_noreq: got sel %b data %h expected 0 0", sel, rdata); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rd((i == 5) ? 8'h1C : 8'(i * 4), v);
      checks++; if (v !== exp_map[i]) begin errors++; $display("FAIL dec_reg%0d: got %h expected %h", i, v, exp_map[i]); end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] v;
    wr(8'h00, 32'd0);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd3);
    wr(8'h10, 32'd1);
    wr(8'h04, 32'd0);
    wr(8'h00, 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rd(8'h08, v);
    checks++; if (v !== 32'd2) begin errors++; $display("FAIL abort_pre_count: got %h expected %h", v, 32'd2); end
    #1 rst = 1'b0;
    rd(8'h08, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL abort_async_count: got %h expected %h", v, 32'd0); end
    rd(8'h0C, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL abort_async_compare: got %h expected %h", v, 32'hFFFF_FFFF); end
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rd(8'h08, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL abort_count_held: got %h expected %h", v, 32'd0); end
    rd(8'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL abort_no_match: got %h expected %h", v, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq: got %b expected 0", irq); end
  endtask

  initial begin
    test_reset();
    test_presc_count();
    test_auto_reload();
    test_wrap();
    test_simultaneous();
    test_decode();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_timer.md
SOC_TIMER -- requirements
Module: soc_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h2000_0000, meaning the timer register window base (256-byte window, aligned).
REQ-002 SHALL have parameter PRESC_W, default 16, meaning the prescaler width in bits.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset, with ports:
- clk_i  input  1  clock; all state is updated on the rising edge.
- rst_i  input  1  asynchronous active-low reset.
- req_i  input  1  data-bus request from the core (ram_req_o).
- we_i  input  1  write enable from the core (ram_we_o); 1 means write, 0 means read.
- addr_i  input  32  byte address from the core (ram_addr_o).
- wdata_i  input  32  write data from the core (ram_wdata_o).
- sel_o  output  1  high when the access hits the timer window; the SoC data mux uses it.
- rdata_o  output  32  read data, returned in the same cycle as the request.
- irq_o  output  1  registered timer interrupt.

Function
REQ-004 SHALL decode sel_o = req_i & (addr_i[31:8] == BASE_ADDR[31:8]), combinationally.
REQ-005 SHALL use word offset addr_i[7:2] and ignore addr_i[1:0]; all accesses are 32-bit.
REQ-006 SHALL implement the register map:
- 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD, remaining bits read 0.
- 0x04 PRESC: PRESC_W bits, zero-extended on read.
- 0x08 COUNT: 32 bits.
- 0x0C COMPARE: 32 bits.
- 0x10 STATUS: bit0 MATCH; writing 1 clears it, writing 0 has no effect.
REQ-007 SHALL return 0 on reads of unmapped offsets and SHALL ignore writes to them.
REQ-008 SHALL drive rdata_o as a combinational function of the current register state when sel_o & ~we_i; otherwise rdata_o = 0.
REQ-009 SHALL commit a write on the clock edge where sel_o & we_i.
REQ-010 SHALL, while EN=1, increment the prescaler counter pcnt each cycle.
REQ-011 SHALL, when pcnt == PRESC, reset pcnt to 0 and assert an internal one-cycle tick in that same cycle; PRESC=0 therefore gives a tick every cycle.
REQ-012 SHALL, while EN=0, hold pcnt and COUNT, and generate no ticks.
REQ-013 SHALL, on a tick, handle COUNT as follows:
- if COUNT == COMPARE: set MATCH, then set COUNT to 0 when AUTO_RELOAD=1, else COUNT+1.
- otherwise: COUNT+1.
REQ-014 SHALL wrap COUNT from 32'hFFFF_FFFF to 0 with no flag.
REQ-015 SHALL give a software write to COUNT priority over a tick in the same cycle; the written value is loaded and no increment or match happens on that edge.
REQ-016 SHALL clear pcnt to 0 on any write to PRESC or to CTRL.
REQ-017 SHALL give MATCH set priority over a simultaneous STATUS write-1-to-clear; MATCH stays 1.
REQ-018 SHALL register irq_o <= MATCH_next & IRQ_EN_next, so irq_o is high one edge after the MATCH-setting tick and stays level until MATCH is cleared or IRQ_EN=0.
REQ-019 SHALL make a read of STATUS side-effect-free.
REQ-020 SHALL make all arithmetic unsigned; the COUNT/COMPARE comparison is a full 32-bit equality.

Reset
REQ-021 SHALL, while rst_i=0, asynchronously clear CTRL, PRESC, pcnt, COUNT, MATCH and irq_o to 0.
REQ-022 SHALL, while rst_i=0, asynchronously set COMPARE to 32'hFFFF_FFFF.
REQ-023 SHALL treat reset asserted mid-count as an immediate abort, with no match on release; the first tick after release requires EN to be rewritten.
REQ-024 SHALL keep sel_o and rdata_o combinational during reset: rdata_o reflects the reset values, and writes are ignored while rst_i=0.

Verification
REQ-025 Reset value check: release reset, read each offset 0x00-0x10 -> 0, 0, 0, FFFF_FFFF, 0; irq_o=0.
REQ-026 Prescaled counting: PRESC=3, then CTRL=1 -> COUNT increments once every 4 cycles; after 40 cycles COUNT=10.
REQ-027 Auto-reload match:
- Stimulus: PRESC=0, COMPARE=5, CTRL=7.
- Required response: COUNT sequence 0,1,2,3,4,5,0; MATCH=1 after the tick at 5; irq_o high the next cycle.
- Stimulus: write STATUS=1.
- Required response: irq_o low one edge later.
REQ-028 Free-running wrap: COUNT=FFFF_FFFE, COMPARE=0, PRESC=0, CTRL=1 -> COUNT goes FFFF_FFFF, then 0, then 1 with MATCH set by the tick at 0; irq_o stays 0 because IRQ_EN=0.
REQ-029 Simultaneous events:
- COUNT write on a tick cycle -> the written value is held.
- STATUS W1C on a match tick -> MATCH remains 1.
REQ-030 Address decode: read at BASE_ADDR+0x100 -> sel_o=0 and rdata_o=0; write to offset 0x1C -> all registers unchanged.
